// File: rtl/dmem_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_unit
// Purpose  : Byte-addressed, big-endian data memory for the MEM stage.
//            Supports lb/lbu/lh/lhu/lw/sb/sh/sw through a request/response
//            handshake with a programmable number of wait states.
// Options  : DMEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses are flagged, stores are suppressed and loads return 0.
//            When undefined, addresses are force-aligned to the access size.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_unit #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        busy
);

  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int NWORDS = DEPTH_BYTES / 4;
  localparam int WAW    = (AW > 2) ? AW - 2 : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic          w_accept;
  logic          w_access;
  logic          w_mem_we;
  logic [AW-1:0] w_in_idx;
  logic [AW-1:0] w_aligned_idx;
  logic [WAW-1:0] w_widx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_rword;
  logic [7:0]    w_rbyte;
  logic [15:0]   w_rhalf;
  logic [31:0]   w_load;
  logic          w_req_mis;

  // Storage is organised as words with big-endian byte lanes; every access
  // that reaches the array is naturally aligned, so one word row suffices.
  logic [31:0] mem [0:NWORDS-1];

  // Address bits above the memory size are ignored by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:AW];

  assign w_accept = req_valid & req_ready;
  assign w_access = (state_q == ST_BUSY) && (wcnt_q == 4'd0);

  // Ready only in IDLE/RESP and never while reset is held.
  assign req_ready  = ~reset & ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign busy       = (state_q == ST_BUSY);
  assign resp_valid = (state_q == ST_RESP);
  assign read_data  = rdata_q;

  // Misalignment detection on the incoming request.
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_req_mis  = ((req_size == SZ_HALF) & address[0]) |
                      (req_size[1] & (|address[1:0]));
  assign misaligned = resp_valid & mis_q;
  assign w_mem_we   = w_access & write_q & ~mis_q;
`else
  assign w_req_mis  = 1'b0;
  assign misaligned = 1'b0;
  assign w_mem_we   = w_access & write_q;
`endif

  // Align the incoming index to the access size before latching it.
  assign w_in_idx = address[AW-1:0];
  always_comb begin
    w_aligned_idx = w_in_idx;
    if (req_size == SZ_HALF) begin
      w_aligned_idx[0] = 1'b0;
    end else if (req_size != SZ_BYTE) begin
      w_aligned_idx[1:0] = 2'b00;
    end
  end

  generate
    if (AW > 2) begin : g_multi_word
      assign w_widx = addr_q[AW-1:2];
    end else begin : g_single_word
      assign w_widx = 1'b0;
    end
  endgenerate

  assign w_lane = addr_q[1:0];

  // Byte enables and lane-replicated store data; be[3] is lane 0 (bits 31:24).
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        w_be    = 4'b1000 >> w_lane;
        w_wlane = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_lane[1] ? 4'b0011 : 4'b1100;
        w_wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = wdata_q;
      end
    endcase
  end

  // Byte-lane writes at the access edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem[w_widx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

  // Read path: select the addressed byte/half and extend it.
  assign w_rword = mem[w_widx];
  always_comb begin
    w_rbyte = w_rword[31:24];
    case (w_lane)
      2'd0:    w_rbyte = w_rword[31:24];
      2'd1:    w_rbyte = w_rword[23:16];
      2'd2:    w_rbyte = w_rword[15:8];
      default: w_rbyte = w_rword[7:0];
    endcase
    w_rhalf = w_lane[1] ? w_rword[15:0] : w_rword[31:16];
    case (size_q)
      SZ_BYTE: w_load = {{24{sign_q & w_rbyte[7]}}, w_rbyte};
      SZ_HALF: w_load = {{16{sign_q & w_rhalf[15]}}, w_rhalf};
      default: w_load = w_rword;
    endcase
  end

  // Request capture on accept, and load result capture on the access edge.
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    write_d = write_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    if (w_accept) begin
      addr_d  = w_aligned_idx;
      size_d  = req_size;
      sign_d  = req_signed;
      write_d = req_write;
      wdata_d = write_data;
      mis_d   = w_req_mis;
    end
    if (w_access && !write_q) begin
      rdata_d = mis_q ? 32'h0 : w_load;
    end
  end

  // Next-state logic for the IDLE -> BUSY -> RESP handshake.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_BUSY;
          wcnt_d  = 4'(WAIT_STATES);
        end
      end
      ST_BUSY: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_accept) begin
          state_d = ST_BUSY;
          wcnt_d  = 4'(WAIT_STATES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // State and request registers; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

endmodule
`default_nettype wire
